boss_shot_tracker: RTL and testbench
====================================

# boss_shot_tracker

Player-shot manager that sits directly upstream of the boss sprite stage. Spawns player shots on fire and advances them once per frame. Tests each live shot against the boss hitbox and emits the single-cycle `is_hit` pulse the boss stage consumes to decrement its life. Also drives the per-pixel `shot_on`/`shot_rgb` layer for the pixel mux, using the same `x`/`y` scan coordinates as the sprite stages.

## Interface
- `SHOT_N`, 8: number of shot slots (2–16).
- `SHOT_SPEED`, 6: pixels a shot moves up per frame.
- `SPAWN_DY`, 16: spawn offset above `player_y`.
- `HIT_HALF_W`, 24: boss hitbox half width.
- `HIT_HALF_H`, 40: boss hitbox half height.
- `SHOT_HALF_W`, 2: shot half width. The shot rectangle is 5×9 px around its centre.
- `SHOT_COLOR`, 12'hF8F: shot pixel colour.
- `COOLDOWN`, 4: frames between autofire shots.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `frame_tick` input 1: one-cycle pulse per frame.
- `fire` input 1: player fire button (synchronized upstream).
- `player_x`, `player_y` input 10 each: player centre.
- `boss_x`, `boss_y` input 10 each: boss centre, i.e. the boss stage's `hecatia_x`/`hecatia_y`.
- `boss_die` input 1: boss dead; suppresses hits.
- `x`, `y` input 10 each: current pixel coordinate.
- `is_hit` output 1: one-cycle pulse per shot that hits.
- `hit_count` output 16: total hits since reset, wraps at 65535→0.
- `shot_on` output 1: current pixel lies inside any live shot.
- `shot_rgb` output 12: equals `SHOT_COLOR`.
- `busy` output 1: scan in progress.

## Operation
- Per-slot state: `active`, `sx[9:0]`, `sy[9:0]`. All arithmetic is 10-bit unsigned; no comparison may underflow.
- Hit test: `sx + HIT_HALF_W >= boss_x` && `sx <= boss_x + HIT_HALF_W` && `sy + HIT_HALF_H >= boss_y` && `sy <= boss_y + HIT_HALF_H`.
- FSM states: IDLE, SCAN, SPAWN.
- IDLE → SCAN on `frame_tick`; the slot index starts at 0.
- SCAN processes one slot per cycle, in index order:
  - inactive slot: unchanged.
  - `sy < SHOT_SPEED`: clear `active`; off-screen, no hit.
  - otherwise `sy -= SHOT_SPEED`, then run the hit test on the new position.
  - hit and `!boss_die`: clear `active`, pulse `is_hit` on the next cycle, increment `hit_count`.
  - hit and `boss_die`: the shot keeps flying; no pulse.
- After slot `SHOT_N-1`, SCAN → SPAWN.
- SPAWN (one cycle):
  - If a shot is pending, allocate the lowest-index inactive slot with `sx = player_x` and `sy = player_y - SPAWN_DY`, or 0 if `player_y < SPAWN_DY`.
  - Clear pending in every case. If all slots are full, the shot is dropped.
  - SPAWN → IDLE.
- Pending fire (default): a rising edge of `fire`, sampled every cycle, sets pending.
- `shot_on` is combinational: OR over active slots of `|x - sx| <= SHOT_HALF_W && |y - sy| <= 4`, computed without underflow.

## Timing
- Reset values: all slots inactive, FSM IDLE, pending 0, cooldown 0, `is_hit` 0, `hit_count` 0, `busy` 0, `shot_on` 0.
- `busy` is high from the cycle after `frame_tick` through SPAWN. Total scan length is `SHOT_N + 1` cycles.
- `is_hit` is registered: slot k's pulse occurs k+2 cycles after `frame_tick`.
  - Several hits in one frame give separate, non-adjacent pulses only if the hitting slots are non-adjacent; adjacent hitting slots give back-to-back pulses.
  - The consumer must count pulses, not levels.
- `frame_tick` while `busy` is ignored, with no queuing.
- A `fire` edge arriving during SCAN is honoured in this frame's SPAWN.
- A `fire` edge in the SPAWN cycle itself sets pending for the next frame.
- Reset mid-scan aborts the scan: all slots are cleared, and any pending pulse is cancelled.
- Slot positions change only inside SCAN/SPAWN, so `shot_on` is stable between frame ticks.

## Configuration
- `SHOT_AUTOFIRE_EN` defined:
  - Pending = `fire` level && cooldown == 0.
  - A successful spawn loads cooldown = `COOLDOWN`.
  - Cooldown decrements on each `frame_tick` while nonzero.
  - A dropped shot (all slots full) does not load cooldown.
- Not defined: edge-triggered fire only, at most one shot per press; the cooldown logic is absent.

## Test plan
- Reset, player (192,400), pulse `fire`, one `frame_tick` → slot 0 active at (192,384); the next tick moves it to (192,378); `is_hit` stays 0.
- Boss (192,100), shot at (200,146), tick → `sy` = 140, within `HIT_HALF_H`:
  - `is_hit` high for exactly 1 cycle, at `frame_tick` + 2;
  - `hit_count` = 1;
  - slot 0 inactive.
- 8 shots live; 9th fire edge → dropped, no slot overwritten. A shot at `sy` = 3 retires on the next tick with no hit.
- `boss_die` = 1, shot crossing the hitbox → no `is_hit`, and the shot continues to `y` = 0. Assert `reset` during SCAN → all slots cleared and `busy` = 0 next cycle.
- Boss at (10,20), shot at (0,66): underflow check → hit detected, no wrap-around false miss. Pixel (2,60) with a shot at (0,60) → `shot_on` = 1.
- With `SHOT_AUTOFIRE_EN`, `fire` held for 10 frames → spawns on frames 1, 5, 9; without it → exactly 1 spawn.

Source files
------------

// File: rtl/boss_shot_tracker.sv
// Player-shot manager: spawns shots on fire, advances them once per frame, pulses is_hit on boss
// contact and drives the shot pixel layer. Define SHOT_AUTOFIRE_EN for held-fire autorepeat.
module boss_shot_tracker #(
  parameter int          SHOT_N      = 8,
  parameter int          SHOT_SPEED  = 6,
  parameter int          SPAWN_DY    = 16,
  parameter int          HIT_HALF_W  = 24,
  parameter int          HIT_HALF_H  = 40,
  parameter int          SHOT_HALF_W = 2,
  parameter logic [11:0] SHOT_COLOR  = 12'hF8F,
  parameter int          COOLDOWN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  boss_x,
  input  logic [9:0]  boss_y,
  input  logic        boss_die,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        is_hit,
  output logic [15:0] hit_count,
  output logic        shot_on,
  output logic [11:0] shot_rgb,
  output logic        busy
);

  localparam int               IDX_W    = $clog2(SHOT_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SHOT_N - 1);

  if (SHOT_N < 2 || SHOT_N > 16 || COOLDOWN < 1) begin : g_bad_param
    $error("boss_shot_tracker: SHOT_N must be 2..16 and COOLDOWN at least 1");
  end

  typedef enum logic [1:0] {IDLE, SCAN, SPAWN} state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [SHOT_N-1:0] active_q;
  logic [9:0]        sx_q [SHOT_N];
  logic [9:0]        sy_q [SHOT_N];
  logic              is_hit_q;
  logic [15:0]       hit_count_q;
  logic              busy_q;

  logic [9:0]        cur_sx;
  logic [9:0]        cur_sy;
  logic [9:0]        new_sy;
  logic [9:0]        spawn_sy;
  logic              retire;
  logic              hit;
  logic              spawn_req;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              do_spawn;

  // Slot under scan and its next position.
  assign cur_sx = sx_q[idx_q];
  assign cur_sy = sy_q[idx_q];
  assign retire = cur_sy < 10'(SHOT_SPEED);
  assign new_sy = cur_sy - 10'(SHOT_SPEED);

  // 11-bit sums so the "+ half size" terms cannot wrap near the screen edges.
  assign hit = ({1'b0, cur_sx} + 11'(HIT_HALF_W) >= {1'b0, boss_x}) &&
               ({1'b0, cur_sx} <= {1'b0, boss_x} + 11'(HIT_HALF_W)) &&
               ({1'b0, new_sy} + 11'(HIT_HALF_H) >= {1'b0, boss_y}) &&
               ({1'b0, new_sy} <= {1'b0, boss_y} + 11'(HIT_HALF_H));

  assign spawn_sy = (player_y < 10'(SPAWN_DY)) ? 10'd0 : player_y - 10'(SPAWN_DY);
  assign do_spawn = (state_q == SPAWN) && spawn_req && free_found;

  // Lowest-index inactive slot: scan downwards so the lowest hit is written last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SHOT_N - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

`ifdef SHOT_AUTOFIRE_EN
  localparam int CD_W = $clog2(COOLDOWN + 1);

  logic [CD_W-1:0] cooldown_q;

  assign spawn_req = fire && (cooldown_q == '0);

  // A dropped shot leaves the cooldown untouched so the next frame retries.
  always_ff @(posedge clk) begin
    if (reset) begin
      cooldown_q <= '0;
    end else if (do_spawn) begin
      cooldown_q <= CD_W'(COOLDOWN);
    end else if (frame_tick && cooldown_q != '0) begin
      cooldown_q <= cooldown_q - 1'b1;
    end
  end
`else
  logic fire_q;
  logic pending_q;
  logic pending_d;

  // SPAWN consumes the request; an edge in that same cycle belongs to the next frame.
  always_comb begin
    pending_d = pending_q | (fire & ~fire_q);
    if (state_q == SPAWN) pending_d = fire & ~fire_q;
  end

  assign spawn_req = pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      fire_q    <= fire;
      pending_q <= pending_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      active_q    <= '0;
      is_hit_q    <= 1'b0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      is_hit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q <= SCAN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (active_q[idx_q]) begin
            if (retire) begin
              active_q[idx_q] <= 1'b0;
            end else if (hit && !boss_die) begin
              active_q[idx_q] <= 1'b0;
              is_hit_q        <= 1'b1;
              hit_count_q     <= hit_count_q + 16'd1;
            end
          end
          if (idx_q == LAST_IDX) state_q <= SPAWN;
          else                   idx_q   <= idx_q + 1'b1;
        end
        SPAWN: begin
          if (do_spawn) active_q[free_idx] <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: positions are a storage array with no reset; active_q alone decides whether a slot matters.
  always_ff @(posedge clk) begin
    if (state_q == SCAN && active_q[idx_q] && !retire) begin
      sy_q[idx_q] <= new_sy;
    end else if (do_spawn) begin
      sx_q[free_idx] <= player_x;
      sy_q[free_idx] <= spawn_sy;
    end
  end

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  always_comb begin
    shot_on = 1'b0;
    for (int i = 0; i < SHOT_N; i++) begin
      if (active_q[i] && abs_diff(x, sx_q[i]) <= 10'(SHOT_HALF_W) && abs_diff(y, sy_q[i]) <= 10'd4)
        shot_on = 1'b1;
    end
  end

  assign is_hit    = is_hit_q;
  assign hit_count = hit_count_q;
  assign busy      = busy_q;
  assign shot_rgb  = SHOT_COLOR;

endmodule

// File: tb/tb_boss_shot_tracker.sv
// Directed plus randomized bench for boss_shot_tracker against a slot-list reference model.
module tb_boss_shot_tracker;

  localparam int SHOT_N   = 8;
  localparam int SPEED    = 6;
  localparam int SPAWN_DY = 16;
  localparam int HALF_W   = 24;
  localparam int HALF_H   = 40;
  localparam int COOLDOWN = 4;
  localparam int OX[4] = '{-3, -2, 2, 3};
  localparam int OY[4] = '{-5, -4, 4, 5};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        fire = 1'b0;
  logic [9:0]  player_x = '0;
  logic [9:0]  player_y = '0;
  logic [9:0]  boss_x = 10'd990;
  logic [9:0]  boss_y = 10'd10;
  logic        boss_die = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        is_hit;
  logic [15:0] hit_count;
  logic        shot_on;
  logic [11:0] shot_rgb;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a plain list of shots in screen coordinates.
  int m_act [SHOT_N];
  int m_sx  [SHOT_N];
  int m_sy  [SHOT_N];
  int m_hits;
  bit m_pend;
  bit m_lvl;
  int m_cd;

  always #5 clk = ~clk;

  boss_shot_tracker dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .player_x(player_x), .player_y(player_y), .boss_x(boss_x), .boss_y(boss_y),
    .boss_die(boss_die), .x(x), .y(y), .is_hit(is_hit), .hit_count(hit_count),
    .shot_on(shot_on), .shot_rgb(shot_rgb), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < SHOT_N; k++) m_act[k] = 0;
    m_hits = 0; m_pend = 0; m_lvl = 0; m_cd = 0;
  endtask

  task automatic model_scan(output int mask);
    mask = 0;
    for (int k = 0; k < SHOT_N; k++) begin
      if (m_act[k] != 0) begin
        if (m_sy[k] < SPEED) m_act[k] = 0;
        else begin
          m_sy[k] = m_sy[k] - SPEED;
          if (absd(m_sx[k], int'(boss_x)) <= HALF_W && absd(m_sy[k], int'(boss_y)) <= HALF_H
              && !boss_die) begin
            m_act[k] = 0;
            mask |= (1 << k);
            m_hits++;
          end
        end
      end
    end
  endtask

  task automatic model_spawn(input bit req, output bit ok);
    ok = 0;
    if (req) begin
      for (int k = 0; k < SHOT_N; k++) begin
        if (!ok && m_act[k] == 0) begin
          ok = 1;
          m_act[k] = 1;
          m_sx[k] = int'(player_x);
          m_sy[k] = (int'(player_y) >= SPAWN_DY) ? int'(player_y) - SPAWN_DY : 0;
        end
      end
    end
  endtask

  task automatic probe(input int px, input int py);
    bit e = 0;
    if (px < 0 || px > 1023 || py < 0 || py > 1023) return;
    for (int k = 0; k < SHOT_N; k++)
      if (m_act[k] != 0 && absd(px, m_sx[k]) <= 2 && absd(py, m_sy[k]) <= 4) e = 1;
    @(negedge clk);
    x = 10'(px); y = 10'(py);
    #1;
    check($sformatf("shot_on(%0d,%0d)", px, py), 32'(shot_on), 32'(e));
  endtask

  task automatic check_pixels();
    for (int k = 0; k < SHOT_N; k++) begin
      probe(m_sx[k], m_sy[k]);
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) probe(m_sx[k] + OX[i], m_sy[k] + OY[j]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; fire = 1'b0; frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    for (int k = 0; k < SHOT_N; k++) begin m_sx[k] = 0; m_sy[k] = 0; end
  endtask

  task automatic pulse_fire();
    @(negedge clk); fire = 1'b1;
    @(negedge clk); fire = 1'b0;
    if (!m_lvl) m_pend = 1;
    m_lvl = 0;
  endtask

  // One frame: fire level is high at offset fire_off (cycles after the tick) or throughout if hold.
  task automatic run_frame(input int fire_off, input bit hold, input bit extra_tick);
    bit prev, lvl, pend_now, pend_next, ok;
    int exp_mask, obs_mask, stray;
    prev = m_lvl; pend_now = m_pend; pend_next = 0;
    for (int c = 0; c <= SHOT_N + 2; c++) begin
      lvl = hold || (c == fire_off);
      if (lvl && !prev) begin
        if (c <= SHOT_N) pend_now = 1;
        else pend_next = 1;
      end
      prev = lvl;
    end
    m_lvl = prev;
    model_scan(exp_mask);
`ifdef SHOT_AUTOFIRE_EN
    if (m_cd > 0) m_cd--;
    if (extra_tick && m_cd > 0) m_cd--;
    model_spawn((hold || fire_off == SHOT_N + 1) && m_cd == 0, ok);
    if (ok) m_cd = COOLDOWN;
    m_pend = 0;
`else
    model_spawn(pend_now, ok);
    m_pend = pend_next;
`endif
    @(negedge clk);
    frame_tick = 1'b1;
    fire = hold || (fire_off == 0);
    obs_mask = 0; stray = 0;
    for (int c = 1; c <= SHOT_N + 2; c++) begin
      @(negedge clk);
      if (is_hit) begin
        if (c >= 2 && c <= SHOT_N + 1) obs_mask |= (1 << (c - 2));
        else stray++;
      end
      if (c == 1)          check("busy_first", 32'(busy), 32'd1);
      if (c == SHOT_N + 1) check("busy_spawn", 32'(busy), 32'd1);
      if (c == SHOT_N + 2) check("busy_done", 32'(busy), 32'd0);
      frame_tick = extra_tick && (c == 3);
      fire = hold || (c == fire_off);
    end
    check("is_hit_slots", 32'(obs_mask), 32'(exp_mask));
    check("is_hit_stray", 32'(stray), 32'd0);
    check("hit_count", 32'(hit_count), 32'(m_hits & 16'hFFFF));
  endtask

  initial begin
    bit ok;
    model_clear();
    for (int k = 0; k < SHOT_N; k++) begin m_sx[k] = 0; m_sy[k] = 0; end
    do_reset();
    check("reset_is_hit", 32'(is_hit), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hit_count", 32'(hit_count), 32'd0);
    check("shot_rgb", 32'(shot_rgb), 32'hF8F);
    probe(0, 0);

    // First shot spawns at (192,384), then advances to (192,378).
    player_x = 10'd192; player_y = 10'd400;
    pulse_fire();
    run_frame(-1, 0, 0);
    probe(192, 384); probe(192, 378);
    run_frame(-1, 0, 0);
    check_pixels();

    // Hit: shot at (200,146) against boss (192,100) lands exactly on the hitbox edge.
    do_reset();
    boss_x = 10'd192; boss_y = 10'd100;
    player_x = 10'd200; player_y = 10'd162;
    pulse_fire();
    run_frame(-1, 0, 0);
    probe(200, 146);
    run_frame(-1, 0, 0);
    check_pixels();

    // Fill all slots, then a ninth request is dropped.
    do_reset();
    boss_x = 10'd990; boss_y = 10'd10;
    player_y = 10'd900;
    for (int n = 0; n < SHOT_N + 1; n++) begin
      player_x = 10'(100 + 60 * n);
      pulse_fire();
      run_frame(-1, 0, 0);
    end
    check_pixels();
    probe(100 + 60 * SHOT_N, 884);

    // Shot at sy=3 retires without a hit even with the boss right there.
    do_reset();
    player_x = 10'd300; player_y = 10'd19;
    pulse_fire();
    run_frame(-1, 0, 0);
    probe(300, 3);
    boss_x = 10'd300; boss_y = 10'd10;
    run_frame(-1, 0, 0);
    probe(300, 3);

    // Dead boss: shot flies through the hitbox until it leaves the top.
    do_reset();
    boss_die = 1'b1; boss_x = 10'd300; boss_y = 10'd200;
    player_x = 10'd300; player_y = 10'd260;
    pulse_fire();
    run_frame(-1, 0, 0);
    for (int f = 0; f < 60 && m_act[0] != 0; f++) begin
      run_frame(-1, 0, 0);
      if (f % 8 == 0) check_pixels();
    end
    check_pixels();
    boss_die = 1'b0;

    // Reset in the middle of a scan cancels slot 2's pending hit pulse.
    do_reset();
    boss_x = 10'd990; boss_y = 10'd10;
    player_x = 10'd100; player_y = 10'd900;
    pulse_fire(); run_frame(-1, 0, 0);
    pulse_fire(); run_frame(-1, 0, 0);
    player_x = 10'd500; player_y = 10'd160;
    pulse_fire(); run_frame(-1, 0, 0);
    boss_x = 10'd500; boss_y = 10'd100;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("is_hit_after_reset", 32'(is_hit), 32'd0);
    reset = 1'b0;
    model_clear();
    check("hit_count_after_reset", 32'(hit_count), 32'd0);
    check_pixels();

    // Underflow corner: boss (10,20), shot (0,66) must hit.
    do_reset();
    boss_x = 10'd10; boss_y = 10'd20;
    player_x = 10'd0; player_y = 10'd82;
    pulse_fire(); run_frame(-1, 0, 0);
    run_frame(-1, 0, 0);
    // Pixel layer near the left edge.
    boss_x = 10'd990; boss_y = 10'd990;
    player_y = 10'd76;
    pulse_fire(); run_frame(-1, 0, 0);
    probe(2, 60); probe(3, 60); probe(0, 56); probe(0, 55); probe(0, 64);
    check_pixels();

    // Fire edges inside SCAN (this frame) and in SPAWN (next frame); a tick while busy is ignored.
    do_reset();
    player_x = 10'd400; player_y = 10'd600;
    run_frame(4, 0, 0);
    check_pixels();
    run_frame(SHOT_N + 1, 0, 0);
    check_pixels();
    run_frame(-1, 0, 1);
    check_pixels();

    // Fire held for ten frames.
    do_reset();
    player_x = 10'd600; player_y = 10'd800;
    for (int f = 0; f < 10; f++) run_frame(-1, 1, 0);
    run_frame(-1, 0, 0);
    for (int j = 0; j < 14; j++) probe(600, 784 - 6 * j);
    check_pixels();

    // Randomized frames with the boss near the shot lanes.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      player_x = 10'($urandom_range(30, 960));
      player_y = 10'($urandom_range(0, 700));
      boss_x   = 10'(int'(player_x) + int'($urandom_range(0, 60)) - 30);
      boss_y   = 10'($urandom_range(0, 600));
      boss_die = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) run_frame(-1, 0, $urandom_range(0, 4) == 0);
      else run_frame(int'($urandom_range(0, SHOT_N + 1)), 0, 0);
      if (f % 3 == 0) check_pixels();
    end
    ok = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
